pixel_packer: RTL and testbench

- Sits on the output side of the image-filter pipeline: it drains the filter's pixel FIFO and packs PACK consecutive DWIDTH_IN-bit pixels into one wide word for the downstream wide FIFO (DMA/host readback).
- Tracks the frame position (x, y) and zero-pads the final word of a frame when the pixel count is not a multiple of PACK.
- Pulses frame_done once the last word of each frame has been written.

---
 rtl/pixel_packer.sv | 140 ++++++++++++++
 tb/tb_pixel_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// Packs PACK consecutive pixels from a FWFT pixel FIFO into one wide word, zero-padding a frame's final word.
// Optional FRAME_CHECKSUM_EN adds a per-frame 16-bit pixel sum output (frame_checksum).
module pixel_packer #(
  parameter int DWIDTH_IN  = 8,
  parameter int PACK       = 4,
  parameter int DWIDTH_OUT = DWIDTH_IN * PACK,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  frame_done
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]           frame_checksum
`endif
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int X_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int Y_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {FILL, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [LANE_W-1:0] lane_reg;
  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic              last_reg;
  logic              frame_done_reg;
  logic              last_pix;
  logic              lane_last;

  assign last_pix  = (x_reg == X_W'(IMG_WIDTH - 1)) && (y_reg == Y_W'(IMG_HEIGHT - 1));
  assign lane_last = (lane_reg == LANE_W'(PACK - 1));
  assign frame_done = frame_done_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshakes are forced low while reset is held, so nothing is popped or pushed during reset.
  always_comb begin
    state_next     = state_reg;
    fifo_in_rd_en  = 1'b0;
    fifo_out_wr_en = 1'b0;
    if (!reset) begin
      case (state_reg)
        FILL: begin
          fifo_in_rd_en = !fifo_in_empty;
          if (fifo_in_rd_en && (lane_last || last_pix)) begin
            state_next = EMIT;
          end
        end
        EMIT: begin
          fifo_out_wr_en = !fifo_out_full;
          if (fifo_out_wr_en) begin
            state_next = FILL;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // last_reg marks that the word being assembled closes the frame; position is rewound at that pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_reg       <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      last_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= fifo_out_wr_en && last_reg;
      if (fifo_in_rd_en) begin
        lane_reg <= lane_last ? '0 : lane_reg + 1'b1;
        if (last_pix) begin
          x_reg    <= '0;
          y_reg    <= '0;
          last_reg <= 1'b1;
        end else if (x_reg == X_W'(IMG_WIDTH - 1)) begin
          x_reg <= '0;
          y_reg <= y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end
      if (fifo_out_wr_en) begin
        lane_reg <= '0;
        last_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      logic [DWIDTH_IN-1:0] lane_data_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          lane_data_reg <= '0;
        end else if (fifo_out_wr_en) begin
          lane_data_reg <= '0;
        end else if (fifo_in_rd_en && (lane_reg == LANE_W'(gi))) begin
          lane_data_reg <= fifo_in_dout;
        end
      end

      assign fifo_out_din[gi*DWIDTH_IN +: DWIDTH_IN] = lane_data_reg;
    end
  endgenerate

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg        <= '0;
      frame_checksum <= '0;
    end else if (fifo_out_wr_en && last_reg) begin
      frame_checksum <= sum_reg;
      sum_reg        <= '0;
    end else if (fifo_in_rd_en) begin
      sum_reg <= sum_reg + 16'(fifo_in_dout);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: 4x3 frames with PACK=4 (dut_a) and PACK=5 (dut_b).
module tb_pixel_packer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // dut_a: PACK=4
  logic        reset_a, rd_en_a, empty_a, wr_en_a, full_a, done_a;
  logic [7:0]  dout_a;
  logic [31:0] din_a;
  // dut_b: PACK=5
  logic        reset_b, rd_en_b, empty_b, wr_en_b, full_b, done_b;
  logic [7:0]  dout_b;
  logic [39:0] din_b;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] chk_a, chk_b;
`endif

  pixel_packer #(.DWIDTH_IN(8), .PACK(4), .DWIDTH_OUT(32), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_a (
    .clock(clock), .reset(reset_a),
    .fifo_in_rd_en(rd_en_a), .fifo_in_dout(dout_a), .fifo_in_empty(empty_a),
    .fifo_out_wr_en(wr_en_a), .fifo_out_din(din_a), .fifo_out_full(full_a),
    .frame_done(done_a)
`ifdef FRAME_CHECKSUM_EN
    , .frame_checksum(chk_a)
`endif
  );

  pixel_packer #(.DWIDTH_IN(8), .PACK(5), .DWIDTH_OUT(40), .IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_b (
    .clock(clock), .reset(reset_b),
    .fifo_in_rd_en(rd_en_b), .fifo_in_dout(dout_b), .fifo_in_empty(empty_b),
    .fifo_out_wr_en(wr_en_b), .fifo_out_din(din_b), .fifo_out_full(full_b),
    .frame_done(done_b)
`ifdef FRAME_CHECKSUM_EN
    , .frame_checksum(chk_b)
`endif
  );

  // Upstream FIFO models: pixel arrays, read index, loaded count, stall flag.
  logic [7:0]  pix_a [0:63];
  logic [7:0]  pix_b [0:63];
  int          rd_idx_a, rd_idx_b, n_a, n_b;
  logic        stall_a, stall_b;
  int          pop_a, pop_b, done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b;
  int          cyc;
  logic [63:0] words_a[$], words_b[$];
  int          wr_cyc_a[$], wr_cyc_b[$];
  int          checks, errors;

  always @(negedge clock) begin
    empty_a = stall_a || (rd_idx_a >= n_a);
    dout_a  = pix_a[rd_idx_a[5:0]];
    empty_b = stall_b || (rd_idx_b >= n_b);
    dout_b  = pix_b[rd_idx_b[5:0]];
  end

  always @(posedge clock) begin
    if (rd_en_a && !empty_a) begin pop_a++; rd_idx_a++; end
    if (rd_en_b && !empty_b) begin pop_b++; rd_idx_b++; end
    if (wr_en_a && !full_a) begin words_a.push_back(64'(din_a)); wr_cyc_a.push_back(cyc); end
    if (wr_en_b && !full_b) begin words_b.push_back(64'(din_b)); wr_cyc_b.push_back(cyc); end
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    words_a.delete(); wr_cyc_a.delete();
    pop_a = 0; done_cnt_a = 0; done_cyc_a = -1; rd_idx_a = 0; n_a = 0;
  endtask

  task automatic clear_b();
    words_b.delete(); wr_cyc_b.delete();
    pop_b = 0; done_cnt_b = 0; done_cyc_b = -1; rd_idx_b = 0; n_b = 0;
  endtask

  task automatic wait_done_a(input int target);
    int k = 0;
    while (done_cnt_a < target && k < 1000) begin @(posedge clock); k++; end
    repeat (4) @(posedge clock);
    #1;
    check("a_done_within_budget", 64'(done_cnt_a >= target), 64'd1);
  endtask

  task automatic wait_done_b(input int target);
    int k = 0;
    while (done_cnt_b < target && k < 1000) begin @(posedge clock); k++; end
    repeat (4) @(posedge clock);
    #1;
    check("b_done_within_budget", 64'(done_cnt_b >= target), 64'd1);
  endtask

  logic [63:0] exp_b3 [0:8];
  logic [31:0] held;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    stall_a = 1'b0; stall_b = 1'b0; full_a = 1'b0; full_b = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    clear_a(); clear_b();
    for (int i = 0; i < 64; i++) begin pix_a[i] = 8'h00; pix_b[i] = 8'h00; end

    // Pixels present during reset must not be popped.
    for (int i = 0; i < 12; i++) begin pix_a[i] = 8'(i + 1); pix_b[i] = 8'(i + 1); end
    n_a = 12; n_b = 12;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rd_en", 64'(rd_en_a), 64'd0);
    check("reset_wr_en", 64'(wr_en_a), 64'd0);
    check("reset_frame_done", 64'(done_a), 64'd0);
    check("reset_din", 64'(din_a), 64'd0);
    check("reset_pops", 64'(pop_a), 64'd0);
`ifdef FRAME_CHECKSUM_EN
    check("reset_checksum", 64'(chk_a), 64'd0);
`endif

    // PACK=4, pixels 1..12, no stalls.
    reset_a = 1'b0; reset_b = 1'b0;
    wait_done_a(1);
    check("p4_word_count", 64'(words_a.size()), 64'd3);
    check("p4_word0", words_a[0], 64'h04030201);
    check("p4_word1", words_a[1], 64'h08070605);
    check("p4_word2", words_a[2], 64'h0C0B0A09);
    check("p4_pops", 64'(pop_a), 64'd12);
    check("p4_done_count", 64'(done_cnt_a), 64'd1);
    check("p4_done_timing", 64'(done_cyc_a), 64'(wr_cyc_a[2] + 1));
    check("p4_throughput", 64'(wr_cyc_a[1] - wr_cyc_a[0]), 64'd5);
`ifdef FRAME_CHECKSUM_EN
    check("p4_checksum", 64'(chk_a), 64'd78);
`endif

    // PACK=5 on the same frame: last word zero-padded.
    wait_done_b(1);
    check("p5_word_count", 64'(words_b.size()), 64'd3);
    check("p5_word0", words_b[0], 64'h0504030201);
    check("p5_word1", words_b[1], 64'h0A09080706);
    check("p5_word2", words_b[2], 64'h000000000C0B);
    check("p5_pops", 64'(pop_b), 64'd12);
    check("p5_done_count", 64'(done_cnt_b), 64'd1);

    // Downstream full for 10 cycles while a word waits in EMIT.
    clear_a();
    full_a = 1'b1;
    for (int i = 0; i < 12; i++) pix_a[i] = 8'(8'h11 + i);
    n_a = 12;
    repeat (8) @(posedge clock);
    #1;
    check("full_first_word", 64'(din_a), 64'h14131211);
    check("full_pops_held", 64'(pop_a), 64'd4);
    held = din_a;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("full_wr_en_low", 64'(wr_en_a), 64'd0);
      check("full_rd_en_low", 64'(rd_en_a), 64'd0);
      check("full_din_stable", 64'(din_a), 64'(held));
    end
    full_a = 1'b0;
    wait_done_a(1);
    check("full_word_count", 64'(words_a.size()), 64'd3);
    check("full_word0", words_a[0], 64'h14131211);
    check("full_word1", words_a[1], 64'h18171615);
    check("full_word2", words_a[2], 64'h1C1B1A19);
    check("full_pops", 64'(pop_a), 64'd12);

    // Three PACK=5 frames with random upstream empty stalls.
    clear_b();
    exp_b3[0] = 64'h0504030201; exp_b3[1] = 64'h0A09080706; exp_b3[2] = 64'h000000000C0B;
    exp_b3[3] = 64'h4544434241; exp_b3[4] = 64'h4A49484746; exp_b3[5] = 64'h000000004C4B;
    exp_b3[6] = 64'h8584838281; exp_b3[7] = 64'h8A89888786; exp_b3[8] = 64'h000000008C8B;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 12; i++) pix_b[f*12 + i] = 8'(f*8'h40 + i + 1);
    n_b = 36;
    for (int k = 0; k < 2000 && done_cnt_b < 3; k++) begin
      @(posedge clock); #1;
      stall_b = 1'($urandom_range(0, 1));
    end
    stall_b = 1'b0;
    wait_done_b(3);
    check("rand_word_count", 64'(words_b.size()), 64'd9);
    for (int i = 0; i < 9; i++) check($sformatf("rand_word%0d", i), words_b[i], exp_b3[i]);
    check("rand_done_count", 64'(done_cnt_b), 64'd3);
    check("rand_pops", 64'(pop_b), 64'd36);

    // Reset after 6 of 12 pixels, then a fresh frame.
    clear_a();
    for (int i = 0; i < 12; i++) pix_a[i] = 8'(8'h01 + i);
    n_a = 12;
    for (int k = 0; k < 200 && pop_a < 6; k++) begin @(posedge clock); #1; end
    check("midrst_pops_before", 64'(pop_a), 64'd6);
    reset_a = 1'b1;
    #1;
    check("midrst_din_cleared", 64'(din_a), 64'd0);
    @(posedge clock); #1;
    clear_a();
    for (int i = 0; i < 12; i++) pix_a[i] = 8'(8'h21 + i);
    n_a = 12;
    @(posedge clock); #1;
    reset_a = 1'b0;
    wait_done_a(1);
    check("midrst_word_count", 64'(words_a.size()), 64'd3);
    check("midrst_word0", words_a[0], 64'h24232221);
    check("midrst_word1", words_a[1], 64'h28272625);
    check("midrst_word2", words_a[2], 64'h2C2B2A29);
    check("midrst_done_count", 64'(done_cnt_a), 64'd1);
    check("midrst_done_timing", 64'(done_cyc_a), 64'(wr_cyc_a[2] + 1));
`ifdef FRAME_CHECKSUM_EN
    check("midrst_checksum", 64'(chk_a), 64'h1CE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
